axis_demux_simple: RTL

// - 1:3 AXI-Stream demultiplexer. The inverse of the 3:1 enable-selected AXIS switch.
// - Routes one slave stream to one of three master ports, chosen by per-port enables.
// - The route is fixed per packet; the output is registered.
// - Sits between a single video/data source and three downstream consumers.

---
 rtl/axis_demux_simple.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/axis_demux_simple.sv
// 1:3 AXI-Stream demultiplexer: one slave stream routed to one of three masters,
// route picked from the enables at packet start and held until tlast.
module axis_demux_simple #(
    parameter int DATAW = 24
) (
    input  logic               aclk,
    input  logic               aresetn,
    input  logic               m0_en,
    input  logic               m1_en,
    input  logic               m2_en,

    input  logic [DATAW-1:0]   s_axis_tdata,
    input  logic               s_axis_tvalid,
    output logic               s_axis_tready,
    input  logic               s_axis_tuser,
    input  logic               s_axis_tlast,
    input  logic               s_axis_tid,
    input  logic               s_axis_tdest,
    input  logic [DATAW/8-1:0] s_axis_tstrb,
    input  logic [DATAW/8-1:0] s_axis_tkeep,

    output logic [DATAW-1:0]   m0_axis_tdata,
    output logic               m0_axis_tvalid,
    input  logic               m0_axis_tready,
    output logic               m0_axis_tuser,
    output logic               m0_axis_tlast,
    output logic               m0_axis_tid,
    output logic               m0_axis_tdest,
    output logic [DATAW/8-1:0] m0_axis_tstrb,
    output logic [DATAW/8-1:0] m0_axis_tkeep,

    output logic [DATAW-1:0]   m1_axis_tdata,
    output logic               m1_axis_tvalid,
    input  logic               m1_axis_tready,
    output logic               m1_axis_tuser,
    output logic               m1_axis_tlast,
    output logic               m1_axis_tid,
    output logic               m1_axis_tdest,
    output logic [DATAW/8-1:0] m1_axis_tstrb,
    output logic [DATAW/8-1:0] m1_axis_tkeep,

    output logic [DATAW-1:0]   m2_axis_tdata,
    output logic               m2_axis_tvalid,
    input  logic               m2_axis_tready,
    output logic               m2_axis_tuser,
    output logic               m2_axis_tlast,
    output logic               m2_axis_tid,
    output logic               m2_axis_tdest,
    output logic [DATAW/8-1:0] m2_axis_tstrb,
    output logic [DATAW/8-1:0] m2_axis_tkeep,

    output logic               drop_pulse
);

    localparam int SW = DATAW / 8;

    typedef enum logic [1:0] {
        IDLE,
        ROUTE,
        DROP
    } state_t;

    state_t            state_q;
    logic [1:0]        cur_sel_q;
    logic [1:0]        out_sel_q;
    logic              out_valid_q;
    logic              drop_q;
    logic [DATAW-1:0]  data_q;
    logic [SW-1:0]     strb_q;
    logic [SW-1:0]     keep_q;
    logic              user_q;
    logic              last_q;
    logic              id_q;
    logic              dest_q;

    logic              sel_ready;
    logic              out_free;
    logic              any_en;
    logic [1:0]        en_sel;
    logic              ready_d;
    logic              discard_d;
    logic [1:0]        route_sel_d;
    logic              accept;
    logic              load;

    always_comb begin
        sel_ready   = 1'b0;
        out_free    = 1'b0;
        any_en      = m0_en | m1_en | m2_en;
        en_sel      = 2'd2;
        ready_d     = 1'b0;
        discard_d   = 1'b0;
        route_sel_d = cur_sel_q;

        case (out_sel_q)
            2'd0:    sel_ready = m0_axis_tready;
            2'd1:    sel_ready = m1_axis_tready;
            default: sel_ready = m2_axis_tready;
        endcase
        out_free = ~out_valid_q | sel_ready;

        if (m0_en) begin
            en_sel = 2'd0;
        end else if (m1_en) begin
            en_sel = 2'd1;
        end

        case (state_q)
            IDLE: begin
                if (any_en) begin
                    ready_d     = out_free;
                    route_sel_d = en_sel;
                end else begin
                    ready_d   = 1'b1;
                    discard_d = 1'b1;
                end
            end
            ROUTE: begin
                ready_d     = out_free;
                route_sel_d = cur_sel_q;
            end
            DROP: begin
                ready_d   = 1'b1;
                discard_d = 1'b1;
            end
            default: ready_d = 1'b0;
        endcase
    end

    // Ready is forced low while reset is held, even though the FSM sits in IDLE.
    assign s_axis_tready = aresetn & ready_d;
    assign accept        = s_axis_tvalid & s_axis_tready;
    assign load          = accept & ~discard_d;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            cur_sel_q   <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            drop_q      <= 1'b0;
            data_q      <= '0;
            strb_q      <= '0;
            keep_q      <= '0;
            user_q      <= 1'b0;
            last_q      <= 1'b0;
            id_q        <= 1'b0;
            dest_q      <= 1'b0;
        end else begin
            drop_q <= accept & discard_d & s_axis_tlast;

            if (load) begin
                data_q      <= s_axis_tdata;
                strb_q      <= s_axis_tstrb;
                keep_q      <= s_axis_tkeep;
                user_q      <= s_axis_tuser;
                last_q      <= s_axis_tlast;
                id_q        <= s_axis_tid;
                dest_q      <= s_axis_tdest;
                out_sel_q   <= route_sel_d;
                out_valid_q <= 1'b1;
            end else if (sel_ready) begin
                out_valid_q <= 1'b0;
            end

            if (accept) begin
                case (state_q)
                    IDLE: begin
                        cur_sel_q <= route_sel_d;
                        if (!s_axis_tlast) begin
                            state_q <= discard_d ? DROP : ROUTE;
                        end
                    end
                    ROUTE, DROP: begin
                        if (s_axis_tlast) begin
                            state_q <= IDLE;
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign m0_axis_tvalid = out_valid_q & (out_sel_q == 2'd0);
    assign m1_axis_tvalid = out_valid_q & (out_sel_q == 2'd1);
    assign m2_axis_tvalid = out_valid_q & (out_sel_q == 2'd2);

    assign m0_axis_tdata = data_q;
    assign m0_axis_tstrb = strb_q;
    assign m0_axis_tkeep = keep_q;
    assign m0_axis_tuser = user_q;
    assign m0_axis_tlast = last_q;
    assign m0_axis_tid   = id_q;
    assign m0_axis_tdest = dest_q;

    assign m1_axis_tdata = data_q;
    assign m1_axis_tstrb = strb_q;
    assign m1_axis_tkeep = keep_q;
    assign m1_axis_tuser = user_q;
    assign m1_axis_tlast = last_q;
    assign m1_axis_tid   = id_q;
    assign m1_axis_tdest = dest_q;

    assign m2_axis_tdata = data_q;
    assign m2_axis_tstrb = strb_q;
    assign m2_axis_tkeep = keep_q;
    assign m2_axis_tuser = user_q;
    assign m2_axis_tlast = last_q;
    assign m2_axis_tid   = id_q;
    assign m2_axis_tdest = dest_q;

    assign drop_pulse = drop_q;

endmodule
